strobe_sched: RTL



---
 rtl/strobe_pkg.sv | 15 +
 rtl/rr_pick.sv | 31 +++
 rtl/strobe_sched.sv | 109 ++++++++++
 3 files changed

// File: rtl/strobe_pkg.sv
// rtl/strobe_pkg.sv - shared state encoding and id-width helper for the strobe scheduler
package strobe_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_FIRE  = 2'd2,
        S_GUARD = 2'd3
    } state_t;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first set req bit at or after ptr, wrapping
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] index
);

    logic [N-1:0]  rot;
    logic [IW-1:0] off;
    logic [IW:0]   sum;

    // rot[j] holds req[(ptr + j) mod N], so the lowest set bit is the winner's offset
    assign rot = N'({req, req} >> ptr);

    always_comb begin
        valid = |rot;
        off   = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) begin
                off = IW'(j);
            end
        end
        sum   = {1'b0, ptr} + {1'b0, off};
        index = (sum >= (IW + 1)'(N)) ? IW'(sum - (IW + 1)'(N)) : IW'(sum);
    end

endmodule

// File: rtl/strobe_sched.sv
// rtl/strobe_sched.sv - round-robin scheduler granting one edge-gated write strobe per slot
module strobe_sched
    import strobe_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int GUARD = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req,
    input  logic                          hold,
    output logic [NREQ-1:0]               en,
    output logic [NREQ-1:0]               ack,
    output logic [id_width(NREQ)-1:0]     grant_id,
    output logic                          busy
);

    localparam int IW = id_width(NREQ);
    localparam logic [3:0] GLOAD = (GUARD > 0) ? 4'(GUARD - 1) : 4'd0;

    state_t          state, state_n;
    logic [IW-1:0]   ptr, ptr_n;
    logic [IW-1:0]   gid_n;
    logic [NREQ-1:0] ack_n;
    logic [3:0]      cnt, cnt_n;
    logic            arb;
    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic [NREQ-1:0] gid_onehot;

    rr_pick #(.N(NREQ), .IW(IW)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .index (pick_idx)
    );

    assign gid_onehot = {{(NREQ - 1){1'b0}}, 1'b1} << grant_id;
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            ptr      <= '0;
            grant_id <= '0;
            ack      <= '0;
            cnt      <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            grant_id <= gid_n;
            ack      <= ack_n;
            cnt      <= cnt_n;
        end
    end

    // FIRE (no guard) and an expired GUARD arbitrate exactly like IDLE, so the
    // spacing between strobes is always 2 + GUARD edges.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        gid_n   = grant_id;
        ack_n   = '0;
        cnt_n   = cnt;
        arb     = 1'b0;
        case (state)
            S_IDLE: arb = 1'b1;
            S_ARM: begin
                state_n = S_FIRE;
                ack_n   = gid_onehot;
                ptr_n   = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
            end
            S_FIRE: begin
                if (GUARD == 0) begin
                    arb = 1'b1;
                end else begin
                    state_n = S_GUARD;
                    cnt_n   = GLOAD;
                end
            end
            S_GUARD: begin
                if (cnt == 4'd0) begin
                    arb = 1'b1;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (arb) begin
            if (!hold && pick_valid) begin
                state_n = S_ARM;
                gid_n   = pick_idx;
            end else begin
                state_n = S_IDLE;
            end
        end
    end

    // Retimed to the falling edge so the gates never see en move near a rising edge
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            en <= '0;
        end else begin
            en <= (state == S_ARM) ? gid_onehot : '0;
        end
    end

endmodule
